// File: rtl/ps2_key_tx.sv
// Device-side PS/2 keyboard transmitter: ps2_key event words -> FIFO -> E0/F0/code Set-2 frames.
// Define PS2_INHIBIT_EN to honour host inhibit (ps2_clk_in held low); otherwise ps2_clk_in is ignored.
module ps2_key_tx #(
    parameter int CLK_DIV = 2400,
    parameter int FIFO_AW = 3
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic        ps2_clk_in,
    output logic        ps2_clk_out,
    output logic        ps2_data_out,
    output logic        busy,
    output logic        dropped
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_POP  = 3'd1;
    localparam logic [2:0] S_HIGH = 3'd2;
    localparam logic [2:0] S_LOW  = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [17:0]      HALF_M1 = 18'(CLK_DIV - 1);
    localparam logic [17:0]      GAP_M1  = 18'(4 * CLK_DIV - 1);
    localparam logic [FIFO_AW:0] FULL_N  = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0] ONE_N   = (FIFO_AW + 1)'(1);

    logic [2:0]         state_q, state_d;
    logic [17:0]        cnt_q, cnt_d;
    logic [3:0]         bit_q, bit_d;
    logic               data_q, data_d;
    logic               inh_q, inh_d;
    logic               e0_q, e0_d, f0_q, f0_d, cd_q, cd_d;
    logic [7:0]         code_q, code_d;
    logic               old_tog_q;
    logic               dropped_q;
    logic [9:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q;

    logic        ev, fifo_empty, fifo_full, push, pop, inhibit;
    logic [9:0]  head;
    logic [7:0]  cur_byte;
    logic [10:0] frame;
    logic [3:0]  nxt_bit;

`ifdef PS2_INHIBIT_EN
    assign inhibit = ~ps2_clk_in;
`else
    logic unused_clk_in;
    assign unused_clk_in = ps2_clk_in;
    assign inhibit       = 1'b0;
`endif

    assign ev         = ps2_key[10] ^ old_tog_q;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_N);
    assign pop        = (state_q == S_POP);
    // A full FIFO still accepts the event when the head leaves in the same cycle.
    assign push       = ev && (!fifo_full || pop);
    assign head       = mem_q[rd_ptr_q];

    // Pending-byte flags are consumed in order E0, F0, code.
    assign cur_byte = e0_q ? 8'hE0 : (f0_q ? 8'hF0 : code_q);
    assign frame    = {1'b1, ~^cur_byte, cur_byte, 1'b0};
    assign nxt_bit  = bit_q + 4'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 18'd1;
        bit_d   = bit_q;
        data_d  = data_q;
        inh_d   = 1'b0;
        e0_d    = e0_q;
        f0_d    = f0_q;
        cd_d    = cd_q;
        code_d  = code_q;
        case (state_q)
            S_IDLE: begin
                data_d = 1'b1;
                if (!fifo_empty && !inhibit) state_d = S_POP;
            end
            S_POP: begin
                e0_d    = head[8];
                f0_d    = ~head[9];
                cd_d    = 1'b1;
                code_d  = head[7:0];
                bit_d   = 4'd0;
                data_d  = 1'b0;
                cnt_d   = HALF_M1;
                state_d = S_HIGH;
            end
            S_HIGH: begin
                inh_d = inhibit;
                if (inhibit && inh_q) begin
                    // Abort without clearing the byte flag so the same byte is resent.
                    state_d = S_GAP;
                    cnt_d   = GAP_M1;
                    data_d  = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = S_LOW;
                    cnt_d   = HALF_M1;
                end
            end
            S_LOW: begin
                if (cnt_q == '0) begin
                    if (bit_q < 4'd10) begin
                        bit_d   = nxt_bit;
                        data_d  = frame[nxt_bit];
                        cnt_d   = HALF_M1;
                        state_d = S_HIGH;
                    end else begin
                        if (e0_q)      e0_d = 1'b0;
                        else if (f0_q) f0_d = 1'b0;
                        else           cd_d = 1'b0;
                        data_d  = 1'b1;
                        cnt_d   = GAP_M1;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (inhibit) begin
                    cnt_d = cnt_q;
                end else if (cnt_q == '0) begin
                    if (e0_q || f0_q || cd_q) begin
                        bit_d   = 4'd0;
                        data_d  = 1'b0;
                        cnt_d   = HALF_M1;
                        state_d = S_HIGH;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                data_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (push && !reset) mem_q[wr_ptr_q] <= ps2_key[9:0];
    end

    always_ff @(posedge clk_sys) begin
        old_tog_q <= ps2_key[10];
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            data_q    <= 1'b1;
            inh_q     <= 1'b0;
            e0_q      <= 1'b0;
            f0_q      <= 1'b0;
            cd_q      <= 1'b0;
            code_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            data_q    <= data_d;
            inh_q     <= inh_d;
            e0_q      <= e0_d;
            f0_q      <= f0_d;
            cd_q      <= cd_d;
            code_q    <= code_d;
            dropped_q <= ev && !push;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + ONE_N;
            else if (pop && !push) count_q <= count_q - ONE_N;
        end
    end

    assign ps2_clk_out  = (state_q != S_LOW);
    assign ps2_data_out = data_q;
    assign busy         = !fifo_empty || (state_q != S_IDLE);
    assign dropped      = dropped_q;
endmodule

// File: tb/tb_ps2_key_tx.sv
// Directed bench for ps2_key_tx: a line monitor decodes frames; each scenario task checks its own results.
module tb_ps2_key_tx;
    localparam int C = 5;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] ps2_key = '0;
    logic        ps2_clk_in = 1'b1;
    logic        ps2_clk_out, ps2_data_out, busy, dropped;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    // monitor state
    int          fall_cnt = 0;
    int          partial_cnt = 0;
    int          drop_cnt = 0;
    int          nb = 0;
    int          idle = 0;
    logic        prev_clk = 1'b1;
    logic [10:0] sh = '0;
    logic [10:0] rxf_q[$];
    logic [10:0] exp_q[$];
    logic [7:0]  exp_b_q[$];

    ps2_key_tx #(.CLK_DIV(C), .FIFO_AW(3)) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .ps2_key     (ps2_key),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_clk_out (ps2_clk_out),
        .ps2_data_out(ps2_data_out),
        .busy        (busy),
        .dropped     (dropped)
    );

    // clock / reset block
    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    // line monitor: data sampled at every falling PS/2 clock
    always @(negedge clk_sys) begin
        if (dropped === 1'b1) drop_cnt++;
        if (reset) begin
            nb = 0;
            idle = 0;
        end else if (prev_clk === 1'b1 && ps2_clk_out === 1'b0) begin
            sh[nb] = ps2_data_out;
            nb++;
            fall_cnt++;
            idle = 0;
            if (nb == 11) begin
                rxf_q.push_back(sh);
                nb = 0;
            end
        end else begin
            idle++;
            if (idle > 3 * C && nb != 0) begin
                partial_cnt++;
                nb = 0;
            end
        end
        prev_clk = ps2_clk_out;
    end

    // driver tasks
    task automatic tick();
        @(negedge clk_sys);
        #1;
    endtask

    task automatic send_event(input logic pressed, input logic ext, input logic [7:0] code);
        ps2_key = {~ps2_key[10], pressed, ext, code};
    endtask

    task automatic wait_data_low(input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            if (ps2_data_out === 1'b0) begin t = cyc; break; end
            tick();
        end
    endtask

    task automatic wait_clk_low(input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            if (ps2_clk_out === 1'b0) begin t = cyc; break; end
            tick();
        end
    endtask

    task automatic wait_idle(input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            if (busy === 1'b0) begin t = cyc; break; end
            tick();
        end
    endtask

    task automatic wait_falls(input int target, input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            if (fall_cnt >= target) begin t = cyc; break; end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        total_cnt++;
        if (ps2_clk_out !== 1'b1) $display("FAIL reset_clk got=%b want=1", ps2_clk_out); else pass_cnt++;
        total_cnt++;
        if (ps2_data_out !== 1'b1) $display("FAIL reset_data got=%b want=1", ps2_data_out); else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else pass_cnt++;
        total_cnt++;
        if (dropped !== 1'b0) $display("FAIL reset_dropped got=%b want=0", dropped); else pass_cnt++;
        reset = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_single_make();
        int t_ev, t, f0;
        logic [10:0] got;
        rxf_q.delete();
        f0 = fall_cnt;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL single_busy_pre got=%b want=0", busy); else pass_cnt++;
        send_event(1'b1, 1'b0, 8'h29);
        t_ev = cyc;
        tick();
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL single_busy_push got=%b want=1", busy); else pass_cnt++;
        wait_data_low(20, t);
        total_cnt++;
        if (t - t_ev != 3) $display("FAIL single_start_lat got=%0d want=3", t - t_ev); else pass_cnt++;
        wait_clk_low(4 * C, t);
        total_cnt++;
        if (t - t_ev != 3 + C) $display("FAIL single_fall_lat got=%0d want=%0d", t - t_ev, 3 + C); else pass_cnt++;
        wait_idle(40 * C, t);
        total_cnt++;
        if (t - t_ev != 3 + 26 * C) $display("FAIL single_idle_lat got=%0d want=%0d", t - t_ev, 3 + 26 * C); else pass_cnt++;
        total_cnt++;
        if (fall_cnt - f0 != 11) $display("FAIL single_falls got=%0d want=11", fall_cnt - f0); else pass_cnt++;
        total_cnt++;
        if (rxf_q.size() != 1) $display("FAIL single_frames got=%0d want=1", rxf_q.size()); else pass_cnt++;
        // 0x29: start 0, 1,0,0,1,0,1,0,0, parity 0, stop 1
        got = (rxf_q.size() > 0) ? rxf_q[0] : 11'hxxx;
        total_cnt++;
        if (got !== 11'h452) $display("FAIL single_frame got=%h want=452", got); else pass_cnt++;
    endtask

    task automatic test_break_ext();
        int t_ev, t;
        logic [10:0] got;
        rxf_q.delete();
        exp_q.delete();
        exp_q.push_back(11'h5C0);  // E0
        exp_q.push_back(11'h7E0);  // F0
        exp_q.push_back(11'h4EA);  // 75
        send_event(1'b0, 1'b1, 8'h75);
        t_ev = cyc;
        tick();
        wait_idle(120 * C, t);
        total_cnt++;
        if (t - t_ev != 3 + 78 * C) $display("FAIL break_dur got=%0d want=%0d", t - t_ev, 3 + 78 * C); else pass_cnt++;
        total_cnt++;
        if (rxf_q.size() != 3) $display("FAIL break_frames got=%0d want=3", rxf_q.size()); else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            got = (k < rxf_q.size()) ? rxf_q[k] : 11'hxxx;
            total_cnt++;
            if (got !== exp_q[k]) $display("FAIL break_byte%0d got=%h want=%h", k, got, exp_q[k]); else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        int t, d0;
        logic [7:0] got;
        rxf_q.delete();
        exp_b_q.delete();
        d0 = drop_cnt;
        exp_b_q.push_back(8'h01);
        for (int i = 0; i < 8; i++) exp_b_q.push_back(8'h10 + 8'(i));
        send_event(1'b1, 1'b0, 8'h01);
        tick();
        wait_data_low(20, t);
        for (int i = 0; i < 10; i++) begin
            send_event(1'b1, 1'b0, 8'h10 + 8'(i));
            tick();
        end
        wait_idle(12 * 27 * C, t);
        total_cnt++;
        if (t < 0) $display("FAIL b2b_timeout got=%0d want>=0", t); else pass_cnt++;
        total_cnt++;
        if (drop_cnt - d0 != 2) $display("FAIL b2b_dropped got=%0d want=2", drop_cnt - d0); else pass_cnt++;
        total_cnt++;
        if (rxf_q.size() != 9) $display("FAIL b2b_frames got=%0d want=9", rxf_q.size()); else pass_cnt++;
        for (int k = 0; k < 9; k++) begin
            got = (k < rxf_q.size()) ? rxf_q[k][8:1] : 8'hxx;
            total_cnt++;
            if (got !== exp_b_q[k]) $display("FAIL b2b_byte%0d got=%h want=%h", k, got, exp_b_q[k]); else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        int t, f0, seen_busy;
        rxf_q.delete();
        f0 = fall_cnt;
        send_event(1'b1, 1'b0, 8'h29);
        tick();
        wait_data_low(20, t);
        send_event(1'b1, 1'b0, 8'h5A);
        tick();
        wait_falls(f0 + 5, 20 * C, t);
        repeat (C) tick();
        reset = 1'b1;
        tick();
        total_cnt++;
        if (ps2_clk_out !== 1'b1) $display("FAIL mid_reset_clk got=%b want=1", ps2_clk_out); else pass_cnt++;
        total_cnt++;
        if (ps2_data_out !== 1'b1) $display("FAIL mid_reset_data got=%b want=1", ps2_data_out); else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL mid_reset_busy got=%b want=0", busy); else pass_cnt++;
        // toggle during the final reset cycle must be absorbed
        send_event(1'b1, 1'b0, 8'h33);
        tick();
        reset = 1'b0;
        f0 = fall_cnt;
        seen_busy = 0;
        for (int i = 0; i < 40 * C; i++) begin
            tick();
            if (busy !== 1'b0) seen_busy++;
        end
        total_cnt++;
        if (seen_busy != 0) $display("FAIL mid_busy_after got=%0d want=0", seen_busy); else pass_cnt++;
        total_cnt++;
        if (fall_cnt - f0 != 0) $display("FAIL mid_falls_after got=%0d want=0", fall_cnt - f0); else pass_cnt++;
        total_cnt++;
        if (rxf_q.size() != 0) $display("FAIL mid_frames got=%0d want=0", rxf_q.size()); else pass_cnt++;
    endtask

    task automatic test_inhibit();
        int t_ev, t, f0, p0;
        logic [10:0] got;
        rxf_q.delete();
        f0 = fall_cnt;
        p0 = partial_cnt;
        send_event(1'b1, 1'b0, 8'h1C);
        t_ev = cyc;
        tick();
        wait_falls(f0 + 4, 20 * C, t);
        repeat (C) tick();
        ps2_clk_in = 1'b0;
        repeat (3) tick();
        ps2_clk_in = 1'b1;
        wait_idle(80 * C, t);
        total_cnt++;
        if (rxf_q.size() != 1) $display("FAIL inh_frames got=%0d want=1", rxf_q.size()); else pass_cnt++;
        got = (rxf_q.size() > 0) ? rxf_q[0] : 11'hxxx;
        total_cnt++;
        if (got !== 11'h438) $display("FAIL inh_frame got=%h want=438", got); else pass_cnt++;
`ifdef PS2_INHIBIT_EN
        total_cnt++;
        if (partial_cnt - p0 != 1) $display("FAIL inh_abort got=%0d want=1", partial_cnt - p0); else pass_cnt++;
`else
        total_cnt++;
        if (partial_cnt - p0 != 0) $display("FAIL inh_abort got=%0d want=0", partial_cnt - p0); else pass_cnt++;
        total_cnt++;
        if (t - t_ev != 3 + 26 * C) $display("FAIL inh_dur got=%0d want=%0d", t - t_ev, 3 + 26 * C); else pass_cnt++;
`endif
    endtask

    initial begin
        test_reset();
        test_single_make();
        test_break_ext();
        test_back_to_back();
        test_reset_mid();
        test_inhibit();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
